// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader
// Read-side consumer of an asynchronous FIFO, running in the FIFO read clock
// domain. Whole words are popped with rrq/rdv and held in a small circular
// buffer. Read requests are only issued while a buffer slot is guaranteed for
// the returning word (credit = buffered words + reads in flight). Each buffered
// word is unpacked into LANES output lanes on a valid/ready byte stream.
//
// Ports
//   rclk          FIFO read clock
//   arst_n        synchronous active-low reset, sampled on rclk rising edge
//   rempty        FIFO empty flag
//   rrq           FIFO read request (combinational from state and rempty)
//   rdata/rdv     FIFO read data and its valid strobe, RD_LAT clocks after rrq
//   m_tdata       output lane, 0 whenever m_tvalid is low
//   m_tvalid      output lane valid
//   m_tready      downstream accept
//   byte_cnt      lanes delivered, wraps at 2^32
//   err_overflow  sticky: a word returned with no buffer space and was dropped
//   err_unexp_rdv sticky: a word returned with no read outstanding
module fifo_byte_reader #(
  parameter int DWIDTH     = 32,
  parameter int BWIDTH     = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int RD_LAT     = 1,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              rclk,
  input  logic              arst_n,
  input  logic              rempty,
  output logic              rrq,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              rdv,
  output logic [BWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [31:0]       byte_cnt,
  output logic              err_overflow,
  output logic              err_unexp_rdv
);

  localparam int LANES = DWIDTH / BWIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int DIS_W = $clog2(RD_LAT + 1) + 1;

  logic [DWIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  buf_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [IDX_W-1:0]  byte_idx;
  logic [DIS_W-1:0]  discard_cnt;

  logic              rd_accept;
  logic              rdv_ok;
  logic              rdv_dec;
  logic              last_lane;
  logic              xfer;
  logic              pop;
  logic              full;
  logic              push;
  logic              overflow;
  logic [CNT_W:0]    credit_used;
  logic [IDX_W-1:0]  lane_sel;
  logic [DWIDTH-1:0] head_word;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A request is only raised while every outstanding word is guaranteed a slot.
  assign credit_used = {1'b0, buf_cnt} + {1'b0, inflight};
  assign rrq         = arst_n & ~rempty & (credit_used < (CNT_W + 1)'(BUF_DEPTH));
  assign rd_accept   = rrq & ~rempty;

  // Words returning for reads issued before reset are ignored for RD_LAT clocks.
  assign rdv_ok    = rdv & (discard_cnt == '0);
  // An unexpected word must not consume the credit of a read issued this clock.
  assign rdv_dec   = rdv_ok & (inflight != '0);

  assign m_tvalid  = (buf_cnt != '0);
  assign last_lane = (byte_idx == IDX_W'(LANES - 1));
  assign xfer      = m_tvalid & m_tready;
  assign pop       = xfer & last_lane;
  assign full      = (buf_cnt == CNT_W'(BUF_DEPTH));
  // A full buffer still accepts a word when the head is leaving in the same clock.
  assign push      = rdv_ok & (~full | pop);
  assign overflow  = rdv_ok & full & ~pop;

  // Lane selection and output byte, forced to zero when nothing is buffered.
  always_comb begin
    lane_sel  = (BIG_ENDIAN != 0) ? (IDX_W'(LANES - 1) - byte_idx) : byte_idx;
    head_word = buf_mem[head];
    m_tdata   = '0;
    if (m_tvalid) begin
      m_tdata = head_word[lane_sel*BWIDTH +: BWIDTH];
    end
  end

  // Control state: pointers, occupancy, credit, lane index, counters, error flags.
  always_ff @(posedge rclk) begin
    if (!arst_n) begin
      head          <= '0;
      tail          <= '0;
      buf_cnt       <= '0;
      inflight      <= '0;
      byte_idx      <= '0;
      byte_cnt      <= '0;
      err_overflow  <= 1'b0;
      err_unexp_rdv <= 1'b0;
      discard_cnt   <= DIS_W'(RD_LAT);
    end else begin
      if (discard_cnt != '0) begin
        discard_cnt <= discard_cnt - 1'b1;
      end

      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end

      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 1'b1;
        2'b01:   buf_cnt <= buf_cnt - 1'b1;
        default: buf_cnt <= buf_cnt;
      endcase

      case ({rd_accept, rdv_dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (xfer) begin
        byte_cnt <= byte_cnt + 32'd1;
        byte_idx <= last_lane ? '0 : byte_idx + 1'b1;
      end

      if (overflow) begin
        err_overflow <= 1'b1;
      end
      if (rdv_ok && (inflight == '0)) begin
        err_unexp_rdv <= 1'b1;
      end
    end
  end

  // Word storage; needs no reset because occupancy is tracked by buf_cnt.
  always_ff @(posedge rclk) begin
    if (arst_n && push) begin
      buf_mem[tail] <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb_fifo_byte_reader
// Directed bench for fifo_byte_reader. Two instances share every input: one
// little-endian and one big-endian. A small FIFO model answers rrq with
// rdv/rdata one clock later. Inputs change and outputs are sampled on the
// falling edge of rclk.
`timescale 1ns/1ps
module tb_fifo_byte_reader;

  logic        rclk = 1'b0;
  logic        arst_n;
  logic        rempty;
  logic        rdv;
  logic        m_tready;
  logic [31:0] rdata;

  logic        rrq, m_tvalid, err_overflow, err_unexp_rdv;
  logic [7:0]  m_tdata;
  logic [31:0] byte_cnt;
  logic        rrq_be, m_tvalid_be, err_overflow_be, err_unexp_rdv_be;
  logic [7:0]  m_tdata_be;
  logic [31:0] byte_cnt_be;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [31:0] fifo_q[$];
  logic        pend_v         = 1'b0;
  logic [31:0] pend_d         = '0;
  logic        rst_n_next     = 1'b0;
  logic        ready_next     = 1'b0;
  logic        force_nonempty = 1'b0;
  logic [7:0]  got_le[$];
  logic [7:0]  got_be[$];
  int          got_cyc[$];

  always #5 rclk = ~rclk;

  fifo_byte_reader #(.DWIDTH(32), .BWIDTH(8), .BUF_DEPTH(2), .RD_LAT(1), .BIG_ENDIAN(0)) dut_le (
    .rclk(rclk), .arst_n(arst_n), .rempty(rempty), .rrq(rrq), .rdata(rdata), .rdv(rdv),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .byte_cnt(byte_cnt),
    .err_overflow(err_overflow), .err_unexp_rdv(err_unexp_rdv)
  );

  fifo_byte_reader #(.DWIDTH(32), .BWIDTH(8), .BUF_DEPTH(2), .RD_LAT(1), .BIG_ENDIAN(1)) dut_be (
    .rclk(rclk), .arst_n(arst_n), .rempty(rempty), .rrq(rrq_be), .rdata(rdata), .rdv(rdv),
    .m_tdata(m_tdata_be), .m_tvalid(m_tvalid_be), .m_tready(m_tready), .byte_cnt(byte_cnt_be),
    .err_overflow(err_overflow_be), .err_unexp_rdv(err_unexp_rdv_be)
  );

  // One clock: apply inputs on the falling edge, then model the FIFO's answer to rrq
  // and record any byte that the next rising edge transfers.
  task automatic cycle();
    @(negedge rclk);
    cyc++;
    arst_n   = rst_n_next;
    m_tready = ready_next;
    rdv      = pend_v;
    rdata    = pend_v ? pend_d : '0;
    pend_v   = 1'b0;
    rempty   = (fifo_q.size() == 0) && !force_nonempty;
    #1;
    if (rrq && !rempty && fifo_q.size() != 0) begin
      pend_v = 1'b1;
      pend_d = fifo_q.pop_front();
    end
    if (arst_n && m_tvalid && m_tready) begin
      got_le.push_back(m_tdata);
      got_be.push_back(m_tdata_be);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_le.size() < n; i++) cycle();
  endtask

  task automatic do_reset();
    fifo_q.delete();
    pend_v     = 1'b0;
    ready_next = 1'b0;
    rst_n_next = 1'b0;
    cycle();
    cycle();
    rst_n_next = 1'b1;
    cycle();
    cycle();
    got_le.delete();
    got_be.delete();
    got_cyc.delete();
  endtask

  // Reset held with the FIFO claiming data and rdv pulsing, then a stale rdv in the release clock.
  task automatic test_reset();
    rst_n_next     = 1'b0;
    ready_next     = 1'b1;
    force_nonempty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pend_v = i[0];
      pend_d = 32'hA5A50000 + 32'(i);
      cycle();
    end
    tests_run++; if (rrq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rrq: got %b want 0", rrq); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_tvalid); end
    tests_run++; if (m_tdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tdata: got %h want 00", m_tdata); end
    tests_run++; if (byte_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_overflow: got %b want 0", err_overflow); end
    tests_run++; if (err_unexp_rdv !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_unexp: got %b want 0", err_unexp_rdv); end
    force_nonempty = 1'b0;
    pend_v     = 1'b1;
    pend_d     = 32'h12345678;
    rst_n_next = 1'b1;
    cycle();
    cycle();
    cycle();
    tests_run++; if (err_unexp_rdv !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_err_unexp: got %b want 0", err_unexp_rdv); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_tvalid: got %b want 0", m_tvalid); end
  endtask

  // One word, little-endian lane order, plus the rempty-to-first-byte latency.
  task automatic test_single_word();
    logic [7:0] exp_b [4];
    int fall_cyc;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    ready_next = 1'b1;
    fifo_q.push_back(32'h44332211);
    fall_cyc = cyc + 1;
    for (int i = 0; i < 12; i++) cycle();
    tests_run++; if (got_le.size() !== 4) begin tests_failed++; $display("[TB] FAIL single_count: got %0d bytes want 4", got_le.size()); end
    for (int i = 0; i < 4 && i < got_le.size(); i++) begin
      tests_run++; if (got_le[i] !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL single_byte%0d: got %h want %h", i, got_le[i], exp_b[i]); end
    end
    if (got_cyc.size() >= 4) begin
      tests_run++; if (got_cyc[0] !== fall_cyc + 2) begin tests_failed++; $display("[TB] FAIL single_latency: first byte cycle %0d want %0d", got_cyc[0], fall_cyc + 2); end
      tests_run++; if (got_cyc[3] - got_cyc[0] !== 3) begin tests_failed++; $display("[TB] FAIL single_contiguous: span %0d want 3", got_cyc[3] - got_cyc[0]); end
    end
    tests_run++; if (byte_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL single_byte_cnt: got %0d want 4", byte_cnt); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_tvalid_after: got %b want 0", m_tvalid); end
  endtask

  // Eight words streamed at full rate: bytes 00..1F with no gaps after the first.
  task automatic test_stream();
    int mism;
    do_reset();
    ready_next = 1'b1;
    for (int w = 0; w < 8; w++) begin
      fifo_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end
    run_until(32, 200);
    for (int i = 0; i < 4; i++) cycle();
    tests_run++; if (got_le.size() !== 32) begin tests_failed++; $display("[TB] FAIL stream_count: got %0d bytes want 32", got_le.size()); end
    mism = 0;
    for (int i = 0; i < got_le.size(); i++) if (got_le[i] !== 8'(i)) mism++;
    tests_run++; if (mism !== 0) begin tests_failed++; $display("[TB] FAIL stream_order: %0d bytes out of order, want 0", mism); end
    if (got_cyc.size() == 32) begin
      tests_run++; if (got_cyc[31] - got_cyc[0] !== 31) begin tests_failed++; $display("[TB] FAIL stream_bubbles: span %0d want 31", got_cyc[31] - got_cyc[0]); end
    end
    tests_run++; if (byte_cnt !== 32'd32) begin tests_failed++; $display("[TB] FAIL stream_byte_cnt: got %0d want 32", byte_cnt); end
    tests_run++; if (err_overflow !== 1'b0 || err_unexp_rdv !== 1'b0) begin tests_failed++; $display("[TB] FAIL stream_errors: got %b%b want 00", err_overflow, err_unexp_rdv); end
  endtask

  // Back-pressure: buffer fills, requests stop, byte holds, then drains in order.
  task automatic test_backpressure();
    int mism;
    do_reset();
    ready_next = 1'b0;
    for (int w = 0; w < 5; w++) begin
      fifo_q.push_back({8'(8'h14 + 4*w), 8'(8'h13 + 4*w), 8'(8'h12 + 4*w), 8'(8'h11 + 4*w)});
    end
    for (int i = 0; i < 10; i++) cycle();
    tests_run++; if (dut_le.buf_cnt !== 2'd2) begin tests_failed++; $display("[TB] FAIL bp_buf_cnt: got %0d want 2", dut_le.buf_cnt); end
    tests_run++; if (rrq !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_rrq: got %b want 0", rrq); end
    tests_run++; if (fifo_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL bp_fifo_left: got %0d words want 3", fifo_q.size()); end
    tests_run++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h11) begin tests_failed++; $display("[TB] FAIL bp_hold: got valid %b data %h want 1 11", m_tvalid, m_tdata); end
    ready_next = 1'b1;
    run_until(20, 300);
    for (int i = 0; i < 4; i++) cycle();
    tests_run++; if (got_le.size() !== 20) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d bytes want 20", got_le.size()); end
    mism = 0;
    for (int i = 0; i < got_le.size(); i++) if (got_le[i] !== 8'(8'h11 + i)) mism++;
    tests_run++; if (mism !== 0) begin tests_failed++; $display("[TB] FAIL bp_order: %0d bytes out of order, want 0", mism); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_err_overflow: got %b want 0", err_overflow); end
    tests_run++; if (byte_cnt !== 32'd20) begin tests_failed++; $display("[TB] FAIL bp_byte_cnt: got %0d want 20", byte_cnt); end
  endtask

  // Lane order of both instances for the same word.
  task automatic test_big_endian();
    logic [7:0] exp_be [4];
    logic [7:0] exp_le [4];
    exp_be = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_le = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    ready_next = 1'b1;
    fifo_q.push_back(32'hA1B2C3D4);
    for (int i = 0; i < 10; i++) cycle();
    tests_run++; if (got_be.size() !== 4) begin tests_failed++; $display("[TB] FAIL be_count: got %0d bytes want 4", got_be.size()); end
    for (int i = 0; i < 4 && i < got_be.size(); i++) begin
      tests_run++; if (got_be[i] !== exp_be[i]) begin tests_failed++; $display("[TB] FAIL be_byte%0d: got %h want %h", i, got_be[i], exp_be[i]); end
      tests_run++; if (got_le[i] !== exp_le[i]) begin tests_failed++; $display("[TB] FAIL le_byte%0d: got %h want %h", i, got_le[i], exp_le[i]); end
    end
    tests_run++; if (byte_cnt_be !== 32'd4 || m_tvalid_be !== 1'b0 || rrq_be !== 1'b0) begin tests_failed++; $display("[TB] FAIL be_final: got cnt %0d valid %b rrq %b want 4 0 0", byte_cnt_be, m_tvalid_be, rrq_be); end
    tests_run++; if (err_overflow_be !== 1'b0 || err_unexp_rdv_be !== 1'b0) begin tests_failed++; $display("[TB] FAIL be_errors: got %b%b want 00", err_overflow_be, err_unexp_rdv_be); end
  endtask

  // A word arriving into a full, stalled buffer is dropped and flagged.
  task automatic test_overflow();
    int mism;
    do_reset();
    ready_next = 1'b0;
    fifo_q.push_back(32'h03020100);
    fifo_q.push_back(32'h07060504);
    for (int i = 0; i < 6; i++) cycle();
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_before: got %b want 0", err_overflow); end
    pend_v = 1'b1;
    pend_d = 32'hDEADBEEF;
    cycle();
    cycle();
    tests_run++; if (err_overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %b want 1", err_overflow); end
    tests_run++; if (err_unexp_rdv !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_unexp: got %b want 1", err_unexp_rdv); end
    tests_run++; if (m_tdata !== 8'h00 || m_tvalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_hold: got valid %b data %h want 1 00", m_tvalid, m_tdata); end
    ready_next = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    tests_run++; if (got_le.size() !== 8) begin tests_failed++; $display("[TB] FAIL ovf_count: got %0d bytes want 8", got_le.size()); end
    mism = 0;
    for (int i = 0; i < got_le.size(); i++) if (got_le[i] !== 8'(i)) mism++;
    tests_run++; if (mism !== 0) begin tests_failed++; $display("[TB] FAIL ovf_order: %0d bytes out of order, want 0", mism); end
  endtask

  // Reset mid-word, restart at lane 0, then an injected rdv with nothing outstanding.
  task automatic test_mid_word_reset();
    logic [7:0] exp_b [8];
    exp_b = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    do_reset();
    ready_next = 1'b1;
    fifo_q.push_back(32'h44332211);
    run_until(2, 20);
    tests_run++; if (got_le.size() !== 2) begin tests_failed++; $display("[TB] FAIL mid_pre_count: got %0d bytes want 2", got_le.size()); end
    rst_n_next = 1'b0;
    cycle();
    cycle();
    tests_run++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || rrq !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_outputs: got valid %b data %h rrq %b want 0 00 0", m_tvalid, m_tdata, rrq); end
    tests_run++; if (byte_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL mid_reset_byte_cnt: got %0d want 0", byte_cnt); end
    rst_n_next = 1'b1;
    cycle();
    cycle();
    got_le.delete();
    got_be.delete();
    got_cyc.delete();
    fifo_q.push_back(32'h88776655);
    for (int i = 0; i < 10; i++) cycle();
    tests_run++; if (err_unexp_rdv !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_unexp_before: got %b want 0", err_unexp_rdv); end
    pend_v = 1'b1;
    pend_d = 32'hCAFEF00D;
    cycle();
    cycle();
    tests_run++; if (err_unexp_rdv !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_unexp_flag: got %b want 1", err_unexp_rdv); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_overflow: got %b want 0", err_overflow); end
    for (int i = 0; i < 8; i++) cycle();
    tests_run++; if (got_le.size() !== 8) begin tests_failed++; $display("[TB] FAIL mid_count: got %0d bytes want 8", got_le.size()); end
    for (int i = 0; i < 8 && i < got_le.size(); i++) begin
      tests_run++; if (got_le[i] !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL mid_byte%0d: got %h want %h", i, got_le[i], exp_b[i]); end
    end
    tests_run++; if (byte_cnt !== 32'd8) begin tests_failed++; $display("[TB] FAIL mid_byte_cnt: got %0d want 8", byte_cnt); end
  endtask

  initial begin
    arst_n   = 1'b0;
    rempty   = 1'b1;
    rdv      = 1'b0;
    rdata    = '0;
    m_tready = 1'b0;
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_big_endian();
    test_overflow();
    test_mid_word_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound on total run time in case the design stalls the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
